// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed 7-segment scan sequencer with dead-time,
// leading-zero blanking and frame tick.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] num_dig,
  input  logic       lzb,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  output logic [7:0] seg_com,
  output logic [7:0] seg_data,
  output logic       frame_tick
);
  localparam int TW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] BLAST = TW'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);
  localparam logic [TW-1:0] SLAST = TW'(SCAN_DIV - BLANK_CYC - 1);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam state_t FIRST = BLANK_CYC > 0 ? BLANK : SHOW;
  state_t state, nstate;
  logic [2:0] idx, nidx;
  logic [TW-1:0] timer, ntimer;
  logic tick, lz;
  logic [3:0] code [8];
  logic [7:0] dp, glyph;
  function automatic logic [7:0] enc(input logic [3:0] h);
    case (h)
      4'h0: enc = 8'hFC;
      4'h1: enc = 8'h60;
      4'h2: enc = 8'hDA;
      4'h3: enc = 8'hF2;
      4'h4: enc = 8'h66;
      4'h5: enc = 8'hB6;
      4'h6: enc = 8'hBE;
      4'h7: enc = 8'hE0;
      4'h8: enc = 8'hFE;
      4'h9: enc = 8'hF6;
      4'hA: enc = 8'hEE;
      4'hB: enc = 8'h3E;
      4'hC: enc = 8'h9C;
      4'hD: enc = 8'h7A;
      4'hE: enc = 8'h9E;
      4'hF: enc = 8'h8E;
    endcase
  endfunction
  always_comb begin
    nstate = state;
    nidx   = idx;
    ntimer = timer + 1'b1;
    tick   = 1'b0;
    if (state != IDLE && !en) begin
      nstate = IDLE;
      nidx   = 3'd0;
      ntimer = '0;
    end else if (state == IDLE) begin
      ntimer = '0;
      if (en) nstate = FIRST;
    end else if (state == BLANK && timer == BLAST) begin
      nstate = SHOW;
      ntimer = '0;
    end else if (state == SHOW && timer == SLAST) begin
      nstate = FIRST;
      ntimer = '0;
      tick   = idx >= num_dig;
      nidx   = tick ? 3'd0 : idx + 3'd1;
    end
  end
  // The digit about to be shown is blanked when it and every active digit above it hold zero.
  always_comb begin
    glyph = enc(code[nidx]);
    lz = lzb && nidx != 3'd0 && nidx <= num_dig;
    for (int k = 0; k < 8; k++)
      if (3'(k) >= nidx && 3'(k) <= num_dig && code[k] != 4'h0) lz = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      timer      <= '0;
      frame_tick <= 1'b0;
      seg_com    <= 8'hFF;
      seg_data   <= 8'h00;
      dp         <= 8'h00;
      for (int k = 0; k < 8; k++) code[k] <= 4'h0;
    end else begin
      state      <= nstate;
      idx        <= nidx;
      timer      <= ntimer;
      frame_tick <= tick;
      seg_com    <= nstate == SHOW ? ~(8'h80 >> nidx) : 8'hFF;
      seg_data   <= nstate == SHOW ? ((lz ? 8'h00 : glyph) | {7'd0, dp[nidx]}) : 8'h00;
      if (wr_en) begin
        code[wr_addr] <= wr_data;
        dp[wr_addr]   <= wr_dp;
      end
    end
  end
endmodule
